// File: rtl/jpu_exc_unit_pkg.sv
// Shared pipeline types for the JPU core: per-instruction exception flags,
// exception codes, CP0 register numbers and the fault priority encoder.
package jpu;

  // Bit 10 (adel) is the highest-priority fault, bit 0 (fpe) the lowest.
  typedef struct packed {
    logic adel;
    logic ades;
    logic ibe;
    logic dbe;
    logic sys;
    logic bp;
    logic ri;
    logic cpu;
    logic ov;
    logic tr;
    logic fpe;
  } exceptions_s;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13,
    EXC_FPE  = 5'd15
  } exc_code_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_e;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Falls through to EXC_INT when no fault flag is set.
  function automatic exc_code_e exc_winner(input exceptions_s e);
    exc_code_e c;
    if (e.adel)      c = EXC_ADEL;
    else if (e.ades) c = EXC_ADES;
    else if (e.ibe)  c = EXC_IBE;
    else if (e.dbe)  c = EXC_DBE;
    else if (e.sys)  c = EXC_SYS;
    else if (e.bp)   c = EXC_BP;
    else if (e.ri)   c = EXC_RI;
    else if (e.cpu)  c = EXC_CPU;
    else if (e.ov)   c = EXC_OV;
    else if (e.tr)   c = EXC_TR;
    else if (e.fpe)  c = EXC_FPE;
    else             c = EXC_INT;
    return c;
  endfunction

endpackage

// File: rtl/jpu_exc_unit_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare match raises a sticky
// pending flag that only an MTC0 Compare clears.
module jpu_timer #(
  parameter logic [15:0] TIMER_PERIOD = 16'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend
);

  logic [15:0] presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic        tick_s;
  logic [31:0] count_inc_s;

  // A software Count write beats the prescaler increment and never signals a match.
  always_comb begin
    tick_s      = (presc_q == (TIMER_PERIOD - 16'd1));
    count_inc_s = count_q + 32'd1;
    presc_d     = presc_q;
    count_d     = count_q;
    compare_d   = compare_q;
    pend_d      = pend_q;
    if (wr_count) begin
      count_d = wdata;
      presc_d = 16'd0;
    end else if (tick_s) begin
      count_d = count_inc_s;
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end
    if (wr_compare) begin
      compare_d = wdata;
      pend_d    = 1'b0;
    end else if (tick_s && !wr_count && (count_inc_s == compare_q)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= 16'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      pend_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign pend    = pend_q;

endmodule

// File: rtl/jpu_exc_unit.sv
// CP0-lite exception controller beside MEM: prioritises faults/interrupts,
// latches Cause/EPC/BadVAddr/Status and redirects the PC for one flush cycle.
module jpu_exc_unit
  import jpu::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter logic [15:0] TIMER_PERIOD = 16'd100,
  parameter int          N_IRQ        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      exc_i,
  input  logic             exc_valid_i,
  input  logic [31:0]      pc_i,
  input  logic             bd_i,
  input  logic [31:0]      badaddr_i,
  input  logic             eret_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [4:0]       cp0_addr_i,
  input  logic             cp0_we_i,
  input  logic [31:0]      cp0_wdata_i,
  output logic [31:0]      cp0_rdata_o,
  output logic             flush_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o
);

  exc_state_e  state_q;
  logic        flush_q, redirect_q;
  logic [31:0] redirect_pc_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q, bd_q;
  logic [1:0]  ip_sw_q;
  exc_code_e   exccode_q;
  logic [31:0] epc_q, badvaddr_q;

  exceptions_s exc_s;
  exc_code_e   winner_s;
  logic [7:0]  ip_s;
  logic        int_pend_s, take_exc_s, take_eret_s, cp0_wr_s;
  logic        wr_count_s, wr_compare_s;
  logic [31:0] count_s, compare_s;
  logic        timer_pend_s;

  jpu_timer #(
    .TIMER_PERIOD(TIMER_PERIOD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (wr_count_s),
    .wr_compare (wr_compare_s),
    .wdata      (cp0_wdata_i),
    .count      (count_s),
    .compare    (compare_s),
    .pend       (timer_pend_s)
  );

  // Hardware IP bits follow the live lines; irq_i[5] shares IP[7] with the timer.
  always_comb begin
    exc_s        = exc_i;
    winner_s     = exc_winner(exc_s);
    ip_s         = {timer_pend_s | irq_i[5], irq_i[4:0], ip_sw_q};
    int_pend_s   = (|(ip_s & im_q)) & ie_q & ~exl_q;
    take_exc_s   = (state_q == ST_RUN) & exc_valid_i & ((|exc_i) | int_pend_s);
    take_eret_s  = (state_q == ST_RUN) & exc_valid_i & eret_i & ~take_exc_s;
    cp0_wr_s     = (state_q == ST_RUN) & exc_valid_i & cp0_we_i & ~take_exc_s & ~take_eret_s;
    wr_count_s   = cp0_wr_s & (cp0_addr_i == CP0_COUNT);
    wr_compare_s = cp0_wr_s & (cp0_addr_i == CP0_COMPARE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      im_q          <= 8'd0;
      exl_q         <= 1'b0;
      ie_q          <= 1'b0;
      bd_q          <= 1'b0;
      ip_sw_q       <= 2'd0;
      exccode_q     <= EXC_INT;
      epc_q         <= 32'd0;
      badvaddr_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (take_exc_s) begin
            exccode_q <= winner_s;
            exl_q     <= 1'b1;
            // A nested exception keeps the original return point.
            if (!exl_q) begin
              epc_q <= bd_i ? (pc_i - 32'd4) : pc_i;
              bd_q  <= bd_i;
            end
            if ((winner_s == EXC_ADEL) || (winner_s == EXC_ADES)) begin
              badvaddr_q <= badaddr_i;
            end
            flush_q       <= 1'b1;
            redirect_q    <= 1'b1;
            redirect_pc_q <= EXC_VECTOR;
            state_q       <= ST_FLUSH;
          end else if (take_eret_s) begin
            exl_q         <= 1'b0;
            flush_q       <= 1'b1;
            redirect_q    <= 1'b1;
            redirect_pc_q <= epc_q;
            state_q       <= ST_FLUSH;
          end else if (cp0_wr_s) begin
            case (cp0_addr_i)
              CP0_BADVADDR: badvaddr_q <= cp0_wdata_i;
              CP0_STATUS: begin
                im_q  <= cp0_wdata_i[15:8];
                exl_q <= cp0_wdata_i[1];
                ie_q  <= cp0_wdata_i[0];
              end
              CP0_CAUSE:    ip_sw_q <= cp0_wdata_i[9:8];
              CP0_EPC:      epc_q   <= cp0_wdata_i;
              default:      ;
            endcase
          end
        end
        ST_FLUSH: begin
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
          state_q    <= ST_RUN;
        end
        default: begin
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
          state_q    <= ST_RUN;
        end
      endcase
    end
  end

  // MFC0 read port.
  always_comb begin
    cp0_rdata_o = 32'd0;
    case (cp0_addr_i)
      CP0_BADVADDR: cp0_rdata_o = badvaddr_q;
      CP0_COUNT:    cp0_rdata_o = count_s;
      CP0_COMPARE:  cp0_rdata_o = compare_s;
      CP0_STATUS:   cp0_rdata_o = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
      CP0_CAUSE:    cp0_rdata_o = {bd_q, 15'h0000, ip_s, 1'b0, exccode_q, 2'b00};
      CP0_EPC:      cp0_rdata_o = epc_q;
      default:      cp0_rdata_o = 32'd0;
    endcase
  end

  assign flush_o       = flush_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_jpu_exc_unit.sv
// Self-checking bench for jpu_exc_unit: directed literal cases followed by a
// randomized run compared every cycle against a behavioural CP0 model.
module tb_jpu_exc_unit;

  localparam logic [31:0] VEC    = 32'h0000_0080;
  localparam int          PERIOD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] exc;
  logic        exc_valid;
  logic [31:0] pc;
  logic        bd;
  logic [31:0] badaddr;
  logic        eret;
  logic [5:0]  irq;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  jpu_exc_unit #(
    .EXC_VECTOR   (VEC),
    .TIMER_PERIOD (16'd4),
    .N_IRQ        (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exc_i         (exc),
    .exc_valid_i   (exc_valid),
    .pc_i          (pc),
    .bd_i          (bd),
    .badaddr_i     (badaddr),
    .eret_i        (eret),
    .irq_i         (irq),
    .cp0_addr_i    (addr),
    .cp0_we_i      (we),
    .cp0_wdata_i   (wdata),
    .cp0_rdata_o   (rdata),
    .flush_o       (flush_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural CP0 state: Status kept as an architectural word.
  logic [31:0] m_status, m_epc, m_bad, m_count, m_compare, m_rpc;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  logic        m_bd, m_pend, m_busy, m_flush, m_redir;
  int          m_presc;
  int          prio_code [11] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 15};
  int          addr_tab  [8]  = '{8, 9, 11, 12, 13, 14, 0, 5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [7:0] ip;
    ip = {m_pend | irq[5], irq[4:0], m_sw};
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return {m_bd, 15'd0, ip, 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] ip;
    logic       intp, wr_cnt, wr_cmp, hit;
    int         code;
    if (rst) begin
      m_status = 0; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0; m_rpc = 0;
      m_sw = 0; m_code = 0; m_bd = 0; m_pend = 0; m_busy = 0; m_flush = 0;
      m_redir = 0; m_presc = 0;
      return;
    end
    ip     = {m_pend | irq[5], irq[4:0], m_sw};
    intp   = ((ip & m_status[15:8]) != 8'd0) && m_status[0] && !m_status[1];
    wr_cnt = 1'b0;
    wr_cmp = 1'b0;
    if (m_busy) begin
      m_busy = 0; m_flush = 0; m_redir = 0;
    end else if (exc_valid && (exc != 11'd0 || intp)) begin
      code = 0;
      for (int i = 0; i < 11; i++) if (code == 0 && exc[10-i]) code = prio_code[i];
      m_code = code[4:0];
      if (!m_status[1]) begin
        m_epc = bd ? pc - 32'd4 : pc;
        m_bd  = bd;
      end
      m_status[1] = 1'b1;
      if (code == 4 || code == 5) m_bad = badaddr;
      m_busy = 1; m_flush = 1; m_redir = 1; m_rpc = VEC;
    end else if (exc_valid && eret) begin
      m_status[1] = 1'b0;
      m_rpc = m_epc;
      m_busy = 1; m_flush = 1; m_redir = 1;
    end else if (exc_valid && we) begin
      case (addr)
        5'd8:    m_bad = wdata;
        5'd9:    wr_cnt = 1'b1;
        5'd11:   wr_cmp = 1'b1;
        5'd12:   m_status = wdata & 32'h0000_FF03;
        5'd13:   m_sw = wdata[9:8];
        5'd14:   m_epc = wdata;
        default: ;
      endcase
    end
    hit = 1'b0;
    if (wr_cnt) begin
      m_count = wdata; m_presc = 0;
    end else if (m_presc == PERIOD - 1) begin
      m_count = m_count + 32'd1; m_presc = 0; hit = (m_count == m_compare);
    end else begin
      m_presc++;
    end
    if (wr_cmp) begin
      m_compare = wdata; m_pend = 0;
    end else if (hit) begin
      m_pend = 1;
    end
  endtask

  task automatic idle();
    rst = 0; exc = 0; exc_valid = 0; pc = 0; bd = 0; badaddr = 0;
    eret = 0; irq = 0; addr = 0; we = 0; wdata = 0;
  endtask

  task automatic step();
    #1;
    chk("rdata", rdata, m_read(addr));
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("flush", {31'd0, flush_o}, {31'd0, m_flush});
    chk("redirect", {31'd0, redirect_o}, {31'd0, m_redir});
    chk("redirect_pc", redirect_pc_o, m_rpc);
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
    idle();
    addr = a;
    #1;
    chk(name, rdata, exp);
    step();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    exc_valid = 1; we = 1; addr = a; wdata = d;
    step();
  endtask

  initial begin
    idle();
    rst = 1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("rst_rpc", redirect_pc_o, 32'd0);
    peek(5'd12, 32'd0, "rst_status");

    // Ov at 0x100, not in a delay slot
    idle(); exc_valid = 1; exc = 11'h004; pc = 32'h100;
    step();
    chk("ov_flush", {31'd0, flush_o}, 32'd1);
    chk("ov_rpc", redirect_pc_o, 32'h80);
    peek(5'd14, 32'h100, "ov_epc");
    chk("ov_unflush", {31'd0, flush_o}, 32'd0);
    peek(5'd13, 32'h30, "ov_cause");
    peek(5'd12, 32'h2, "ov_status");

    // AdEL+Ov in a delay slot
    mtc0(5'd12, 32'd0);
    idle(); exc_valid = 1; exc = 11'h404; pc = 32'h204; bd = 1; badaddr = 32'h33;
    step();
    peek(5'd13, 32'h8000_0010, "adel_cause");
    peek(5'd14, 32'h200, "adel_epc");
    peek(5'd8, 32'h33, "adel_badvaddr");

    // Interrupt taken, then masked by EXL
    mtc0(5'd12, 32'h401);
    idle(); exc_valid = 1; irq = 6'd1; pc = 32'h100;
    step();
    chk("int_redirect", {31'd0, redirect_o}, 32'd1);
    peek(5'd13, 32'h0, "int_cause");
    peek(5'd12, 32'h403, "int_status");
    idle(); exc_valid = 1; irq = 6'd1;
    step();
    chk("int_masked", {31'd0, redirect_o}, 32'd0);

    // ERET, then ERET+Sys
    idle(); exc_valid = 1; eret = 1;
    step();
    chk("eret_rpc", redirect_pc_o, 32'h100);
    peek(5'd12, 32'h401, "eret_status");
    idle(); exc_valid = 1; eret = 1; exc = 11'h040; pc = 32'h300;
    step();
    chk("eretsys_rpc", redirect_pc_o, 32'h80);
    peek(5'd12, 32'h403, "eretsys_status");
    peek(5'd13, 32'h20, "eretsys_cause");

    // Timer: Compare=2 matches on the 8th edge after reset
    idle(); rst = 1;
    step();
    mtc0(5'd11, 32'd2);
    for (int i = 0; i < 6; i++) begin idle(); step(); end
    peek(5'd13, 32'h0, "tmr_before");
    peek(5'd13, 32'h8000, "tmr_hit");
    mtc0(5'd11, 32'd5);
    peek(5'd13, 32'h0, "tmr_clear");
    peek(5'd9, 32'd2, "tmr_count");

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin idle(); step(); end
    peek(5'd9, 32'hFFFF_FFFF, "wrap_pre");
    peek(5'd9, 32'h0, "wrap_post");

    // Reset in the flush cycle
    idle(); exc_valid = 1; exc = 11'h004;
    step();
    chk("rstfl_flush1", {31'd0, flush_o}, 32'd1);
    idle(); rst = 1;
    step();
    chk("rstfl_flush0", {31'd0, flush_o}, 32'd0);
    chk("rstfl_rpc", redirect_pc_o, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      exc_valid = ($urandom_range(0, 3) != 0);
      exc       = ($urandom_range(0, 9) == 0) ? 11'($urandom & $urandom) : 11'd0;
      eret      = ($urandom_range(0, 19) == 0);
      irq       = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      pc        = $urandom & 32'hFFFF_FFFC;
      bd        = 1'($urandom_range(0, 1));
      badaddr   = $urandom;
      we        = ($urandom_range(0, 3) == 0);
      addr      = 5'(addr_tab[$urandom_range(0, 7)]);
      wdata     = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
